adc_sample_formatter: RTL

Capture-side stage between the ADC pins and the dataGenerator sample FIFO. It runs entirely in the 32 MHz ADC clock domain. It synchronises the FX3 collectData/testMode controls, discards ADC pipeline-settling samples at capture start, and converts each 10-bit unsigned ADC sample, or a test-pattern counter, into a 16-bit signed scaled word with a FIFO write strobe. It detects FIFO overflow and freezes capture until the FX3 restarts collection.

---
 rtl/adc_sample_formatter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adc_sample_formatter.sv
// adc_sample_formatter
// Sits between the ADC pins and the sample FIFO, entirely in the adcClk domain.
// - Synchronises collectData and testMode.
// - Drops the ADC pipeline-settling samples at the start of each capture.
// - Formats each 10-bit offset-binary sample into a 16-bit signed word and
//   writes one word per cycle while capturing.
// - On FIFO overflow, freezes capture until collectData is toggled.
// Optional feature: define ADC_TEST_PATTERN_EN to compile in the test-pattern
// counter. When undefined, testMode is ignored and the ADC is always the source.
`timescale 1ns/1ps

module adc_sample_formatter #(
   parameter int SYNC_STAGES     = 2,   // 2..4
   parameter int DISCARD_SAMPLES = 8    // 0..255
) (
   input  logic        adcClk,
   input  logic        nReset,
   input  logic [9:0]  adcData,
   input  logic        collectData,
   input  logic        testMode,
   input  logic        fifoFull,
   output logic        fifoWrite,
   output logic [15:0] fifoData,
   output logic        overflow,
   output logic        capturing
);

   typedef enum logic [1:0] {IDLE, START, CAPTURE, HALT} state_t;

   // With no discards, START still lasts one cycle.
   localparam logic [7:0] DISCARD_LAST =
      8'((DISCARD_SAMPLES == 0) ? 0 : DISCARD_SAMPLES - 1);

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] collect_chain;
   logic                   collect_sync;
   logic [9:0]             s1;
   logic [7:0]             discard_cnt;
   logic                   write_d;
   logic                   overflow_set;
   logic                   start_entry;
   logic [9:0]             src_sample;

   // Offset-binary to two's complement, left-justified in 16 bits.
   function automatic logic [15:0] fmt_word(input logic [9:0] sample);
      return {~sample[9], sample[8:0], 6'b000000};
   endfunction

   // collectData synchroniser chain
   // NOTE: state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge adcClk or negedge nReset) begin
      if (!nReset) collect_chain <= '0;
      else         collect_chain <= {collect_chain[SYNC_STAGES-2:0], collectData};
   end
   assign collect_sync = collect_chain[SYNC_STAGES-1];

`ifdef ADC_TEST_PATTERN_EN
   logic [SYNC_STAGES-1:0] test_chain;
   logic                   test_sync;
   logic                   mode_test;
   logic [9:0]             test_cnt;

   // testMode synchroniser chain
   always_ff @(posedge adcClk or negedge nReset) begin
      if (!nReset) test_chain <= '0;
      else         test_chain <= {test_chain[SYNC_STAGES-2:0], testMode};
   end
   assign test_sync = test_chain[SYNC_STAGES-1];

   // Mode latched at START entry; counter runs 0..1020 while capturing
   always_ff @(posedge adcClk or negedge nReset) begin
      if (!nReset) begin
         mode_test <= 1'b0;
         test_cnt  <= '0;
      end else if (start_entry) begin
         mode_test <= test_sync;
         test_cnt  <= '0;
      end else if (state_q == CAPTURE) begin
         test_cnt  <= (test_cnt == 10'd1020) ? 10'd0 : test_cnt + 10'd1;
      end
   end

   assign src_sample = mode_test ? test_cnt : s1;
`else
   logic unused_test_mode;
   assign unused_test_mode = testMode;
   assign src_sample       = s1;
`endif

   // Input pipeline stage plus state register and discard counter
   always_ff @(posedge adcClk or negedge nReset) begin
      if (!nReset) begin
         s1          <= '0;
         state_q     <= IDLE;
         discard_cnt <= '0;
      end else begin
         s1      <= adcData;
         state_q <= state_d;
         if (start_entry)            discard_cnt <= '0;
         else if (state_q == START)  discard_cnt <= discard_cnt + 8'd1;
      end
   end

   // Next state and write decision; collectSync low beats overflow detection
   always_comb begin
      // NOTE: every output of this block gets a default first, so no latches.
      state_d      = state_q;
      write_d      = 1'b0;
      overflow_set = 1'b0;
      start_entry  = 1'b0;
      case (state_q)
         IDLE: begin
            if (collect_sync) begin
               state_d     = START;
               start_entry = 1'b1;
            end
         end
         START: begin
            if (!collect_sync)                     state_d = IDLE;
            else if (discard_cnt == DISCARD_LAST)  state_d = CAPTURE;
         end
         CAPTURE: begin
            if (!collect_sync) begin
               state_d = IDLE;
            end else if (fifoFull) begin
               state_d      = HALT;
               overflow_set = 1'b1;
            end else begin
               write_d = 1'b1;
            end
         end
         HALT: begin
            if (!collect_sync) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs; capturing shares the fifoWrite pipeline stage
   always_ff @(posedge adcClk or negedge nReset) begin
      if (!nReset) begin
         fifoWrite <= 1'b0;
         fifoData  <= '0;
         overflow  <= 1'b0;
         capturing <= 1'b0;
      end else begin
         fifoWrite <= write_d;
         capturing <= (state_q == CAPTURE);
         if (write_d)           fifoData <= fmt_word(src_sample);
         if (start_entry)       overflow <= 1'b0;
         else if (overflow_set) overflow <= 1'b1;
      end
   end

endmodule
